// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the LCD SPI sequencer: FSM states and init ROM entry layout.
// The init ROM itself is only built when SPI_SEQ_INIT_ROM_EN is defined.
package spi_seq_pkg;

   typedef enum logic [3:0] {
      StRstHold,
      StRstWait,
      StInitFetch,
      StInitExec,
      StInitDelay,
      StReady,
      StXferStart,
      StXferWait,
      StFault
   } seq_state_e;

   // Init ROM entry: {is_delay, dc, byte}
   localparam int unsigned IS_DELAY_BIT = 9;
   localparam int unsigned DC_BIT       = 8;
   localparam int unsigned ROM_ENTRY_W  = 10;

   localparam logic [ROM_ENTRY_W-1:0] END_MARKER = 10'h200;

   localparam int unsigned INIT_ROM_DEPTH = 8;
   localparam int unsigned INIT_ROM_AW    = $clog2(INIT_ROM_DEPTH);

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Registered synchronous-read LCD init table; present only when SPI_SEQ_INIT_ROM_EN is defined.
// Entries are {is_delay, dc, byte}; a delay entry with byte 0 terminates the table.
`ifdef SPI_SEQ_INIT_ROM_EN
module lcd_init_rom
   import spi_seq_pkg::*;
(
   input  logic                   clk_i,
   input  logic [INIT_ROM_AW-1:0] addr_i,
   output logic [ROM_ENTRY_W-1:0] entry_o
);

   logic [ROM_ENTRY_W-1:0] entry_d, entry_q;

   always_comb begin
      entry_d = END_MARKER;
      case (addr_i)
         INIT_ROM_AW'(0): entry_d = {1'b0, 1'b0, 8'h01};  // software reset
         INIT_ROM_AW'(1): entry_d = {1'b1, 1'b0, 8'd3};   // 3 delay units
         INIT_ROM_AW'(2): entry_d = {1'b0, 1'b0, 8'h11};  // sleep out
         INIT_ROM_AW'(3): entry_d = {1'b0, 1'b0, 8'h3A};  // pixel format
         INIT_ROM_AW'(4): entry_d = {1'b0, 1'b1, 8'h55};
         INIT_ROM_AW'(5): entry_d = {1'b0, 1'b0, 8'h29};  // display on
         default:         entry_d = END_MARKER;
      endcase
   end

   always_ff @(posedge clk_i) begin
      entry_q <= entry_d;
   end

   assign entry_o = entry_q;

endmodule
`endif

// File: rtl/lcd_spi_sequencer.sv
// Sequences LCD reset, init-table replay and renderer byte writes onto a single-byte SPI master.
// SPI_SEQ_INIT_ROM_EN enables panel reset and init ROM; without it the block starts in READY.
module lcd_spi_sequencer
   import spi_seq_pkg::*;
#(
   parameter int unsigned RST_CYCLES      = 1000,
   parameter int unsigned POST_RST_CYCLES = 5000,
   parameter int unsigned DELAY_UNIT      = 1000,
   parameter int unsigned TIMEOUT         = 1024
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       req_valid_i,
   input  logic       req_dc_i,
   input  logic [7:0] req_data_i,
   output logic       req_ready_o,
   output logic       init_done_o,
   output logic       busy_o,
   output logic       fault_o,
   output logic       spi_start_o,
   output logic [7:0] spi_data_o,
   input  logic       spi_done_i,
   output logic       lcd_dc_o,
   output logic       lcd_rst_no
);

   // One down-counter serves reset hold, post-reset wait, init delays and the done timeout.
   localparam int unsigned CntMax = max_u(max_u(RST_CYCLES, POST_RST_CYCLES),
                                          max_u(TIMEOUT, 255 * DELAY_UNIT));
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam logic [CntW-1:0] TimeoutLoad = CntW'(TIMEOUT - 1);

   seq_state_e      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            req_ready_q, req_ready_d;
   logic            init_done_q, init_done_d;
   logic            busy_q, busy_d;
   logic            fault_q, fault_d;
   logic            spi_start_q, spi_start_d;
   logic [7:0]      spi_data_q, spi_data_d;
   logic            lcd_dc_q, lcd_dc_d;

`ifdef SPI_SEQ_INIT_ROM_EN
   localparam logic [CntW-1:0] RstLoad  = CntW'(RST_CYCLES - 1);
   // The init fetch cycle is part of the post-reset wait.
   localparam logic [CntW-1:0] PostLoad = CntW'(POST_RST_CYCLES - 2);
   // Fetch/exec cycles around a delay entry are folded into its count.
   localparam int unsigned DelayOverhead = 3;
   localparam logic [ROM_ENTRY_W-1:0] EndMask = ~(ROM_ENTRY_W'(1) << DC_BIT);

   logic [INIT_ROM_AW-1:0] idx_q, idx_d;
   logic [ROM_ENTRY_W-1:0] rom_entry;
   logic                   lcd_rst_n_q, lcd_rst_n_d;
   logic [31:0]            delay_cycles;
   logic [CntW-1:0]        delay_load;
   logic                   rom_is_end;

   lcd_init_rom u_init_rom (
      .clk_i   (clk_i),
      .addr_i  (idx_d),
      .entry_o (rom_entry)
   );

   assign delay_cycles = {24'd0, rom_entry[7:0]} * DELAY_UNIT;
   assign delay_load   = (delay_cycles > 32'(DelayOverhead)) ?
                         CntW'(delay_cycles - 32'(DelayOverhead)) : '0;
   assign rom_is_end   = (rom_entry & EndMask) == END_MARKER;
   assign lcd_rst_no   = lcd_rst_n_q;
`else
   localparam logic [CntW-1:0] RstLoad = '0;

   assign lcd_rst_no = 1'b1;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= StRstHold;
         cnt_q       <= RstLoad;
         req_ready_q <= 1'b0;
         init_done_q <= 1'b0;
         busy_q      <= 1'b1;
         fault_q     <= 1'b0;
         spi_start_q <= 1'b0;
         spi_data_q  <= 8'h00;
         lcd_dc_q    <= 1'b0;
`ifdef SPI_SEQ_INIT_ROM_EN
         idx_q       <= '0;
         lcd_rst_n_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         init_done_q <= init_done_d;
         busy_q      <= busy_d;
         fault_q     <= fault_d;
         spi_start_q <= spi_start_d;
         spi_data_q  <= spi_data_d;
         lcd_dc_q    <= lcd_dc_d;
`ifdef SPI_SEQ_INIT_ROM_EN
         idx_q       <= idx_d;
         lcd_rst_n_q <= lcd_rst_n_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_ready_d = 1'b0;
      init_done_d = init_done_q;
      fault_d     = fault_q;
      spi_start_d = 1'b0;
      spi_data_d  = spi_data_q;
      lcd_dc_d    = lcd_dc_q;
`ifdef SPI_SEQ_INIT_ROM_EN
      idx_d       = idx_q;
      lcd_rst_n_d = lcd_rst_n_q;
`endif

      case (state_q)
         StRstHold: begin
`ifdef SPI_SEQ_INIT_ROM_EN
            if (cnt_q == '0) begin
               state_d     = StRstWait;
               lcd_rst_n_d = 1'b1;
               cnt_d       = PostLoad;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
`else
            state_d     = StReady;
            init_done_d = 1'b1;
            req_ready_d = 1'b1;
`endif
         end
`ifdef SPI_SEQ_INIT_ROM_EN
         StRstWait: begin
            if (cnt_q == '0) begin
               state_d = StInitFetch;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StInitFetch: begin
            state_d = StInitExec;
            if (!rom_entry[IS_DELAY_BIT]) begin
               spi_start_d = 1'b1;
               spi_data_d  = rom_entry[7:0];
               lcd_dc_d    = rom_entry[DC_BIT];
               cnt_d       = TimeoutLoad;
            end
         end
         StInitExec: begin
            if (rom_is_end) begin
               state_d     = StReady;
               init_done_d = 1'b1;
               req_ready_d = 1'b1;
            end else if (rom_entry[IS_DELAY_BIT]) begin
               state_d = StInitDelay;
               cnt_d   = delay_load;
            end else if (spi_done_i && !spi_start_q) begin
               state_d = StInitFetch;
               idx_d   = idx_q + INIT_ROM_AW'(1);
            end else if (cnt_q == '0) begin
               state_d = StFault;
               fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StInitDelay: begin
            if (cnt_q == '0) begin
               state_d = StInitFetch;
               idx_d   = idx_q + INIT_ROM_AW'(1);
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
`endif
         StReady: begin
            req_ready_d = 1'b1;
            if (req_valid_i && req_ready_q) begin
               state_d     = StXferStart;
               req_ready_d = 1'b0;
               spi_start_d = 1'b1;
               spi_data_d  = req_data_i;
               lcd_dc_d    = req_dc_i;
               cnt_d       = TimeoutLoad;
            end
         end
         StXferStart: begin
            if (cnt_q == '0) begin
               state_d = StFault;
               fault_d = 1'b1;
            end else begin
               state_d = StXferWait;
               cnt_d   = cnt_q - CntW'(1);
            end
         end
         StXferWait: begin
            if (spi_done_i) begin
               state_d     = StReady;
               req_ready_d = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = StFault;
               fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StFault: begin
            state_d = StFault;
         end
         default: begin
            state_d = StRstHold;
         end
      endcase

      busy_d = !(state_d inside {StReady, StFault});
   end

   assign req_ready_o = req_ready_q;
   assign init_done_o = init_done_q;
   assign busy_o      = busy_q;
   assign fault_o     = fault_q;
   assign spi_start_o = spi_start_q;
   assign spi_data_o  = spi_data_q;
   assign lcd_dc_o    = lcd_dc_q;

endmodule

// File: tb/tb_lcd_spi_sequencer.sv
// Self-checking bench for lcd_spi_sequencer: vector table of renderer writes plus
// hand-written reset, timeout, spurious-done and init (when SPI_SEQ_INIT_ROM_EN) sequences.
module tb_lcd_spi_sequencer;

   localparam int unsigned DoneLat = 20;
   localparam int NV = 5;
`ifdef SPI_SEQ_INIT_ROM_EN
   localparam logic ExpRstN = 1'b0;
`else
   localparam logic ExpRstN = 1'b1;
`endif

   typedef struct {
      logic       dc;
      logic [7:0] data;
      logic       b2b;
      logic [7:0] exp_data;
      logic       exp_dc;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid, req_dc;
   logic [7:0] req_data;
   logic       req_ready, init_done, busy, fault, spi_start, spi_done, lcd_dc, lcd_rst_n;
   logic [7:0] spi_data;

   logic       model_done, model_active, model_hang, spur_done;
   int         model_cnt;

   int checks = 0;
   int errors = 0;
   vec_t vecs [NV];

   always #5 clk = ~clk;

   assign spi_done = model_done | spur_done;

   lcd_spi_sequencer #(
      .RST_CYCLES      (4),
      .POST_RST_CYCLES (6),
      .DELAY_UNIT      (5),
      .TIMEOUT         (50)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid),
      .req_dc_i    (req_dc),
      .req_data_i  (req_data),
      .req_ready_o (req_ready),
      .init_done_o (init_done),
      .busy_o      (busy),
      .fault_o     (fault),
      .spi_start_o (spi_start),
      .spi_data_o  (spi_data),
      .spi_done_i  (spi_done),
      .lcd_dc_o    (lcd_dc),
      .lcd_rst_no  (lcd_rst_n)
   );

   // SPI master model: done pulse DoneLat cycles after the start cycle, unless hung
   always @(posedge clk) begin
      if (!rst_n) begin
         model_done   <= 1'b0;
         model_active <= 1'b0;
         model_cnt    <= 0;
      end else begin
         model_done <= 1'b0;
         if (spi_start && !model_hang) begin
            model_active <= 1'b1;
            model_cnt    <= 1;
         end else if (model_active) begin
            if (model_cnt == DoneLat - 1) begin
               model_done   <= 1'b1;
               model_active <= 1'b0;
            end
            model_cnt <= model_cnt + 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_spi_start"}, 32'(spi_start), 0);
      chk({tag, "_spi_data"}, 32'(spi_data), 0);
      chk({tag, "_lcd_dc"}, 32'(lcd_dc), 0);
      chk({tag, "_lcd_rst_n"}, 32'(lcd_rst_n), 32'(ExpRstN));
      chk({tag, "_req_ready"}, 32'(req_ready), 0);
      chk({tag, "_init_done"}, 32'(init_done), 0);
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_fault"}, 32'(fault), 0);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 5000) begin
         tick();
         n++;
      end
      chk("ready_reached", 32'(req_ready), 1);
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      int   starts, unstable;
      logic seen_done;
      v = vecs[i];
      req_valid = 1'b1;
      req_dc    = v.dc;
      req_data  = v.data;
      tick();
      chk("hs_start", 32'(spi_start), 1);
      chk("hs_data", 32'(spi_data), 32'(v.exp_data));
      chk("hs_dc", 32'(lcd_dc), 32'(v.exp_dc));
      chk("hs_ready_low", 32'(req_ready), 0);
      if (v.b2b && i + 1 < NV) begin
         req_dc   = vecs[i+1].dc;
         req_data = vecs[i+1].data;
      end else begin
         req_valid = 1'b0;
      end
      starts = 0;
      unstable = 0;
      seen_done = 1'b0;
      for (int n = 0; n < 60 && !seen_done; n++) begin
         tick();
         if (spi_start) starts++;
         if (spi_data !== v.exp_data || lcd_dc !== v.exp_dc || req_ready !== 1'b0) unstable++;
         if (spi_done) seen_done = 1'b1;
      end
      chk("done_seen", 32'(seen_done), 1);
      chk("extra_start", 32'(starts), 0);
      chk("inflight_stable", 32'(unstable), 0);
      tick();
      chk("ready_after_done", 32'(req_ready), 1);
   endtask

   initial begin
      int n, starts;
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_dc = 1'b0;
      req_data = 8'h00;
      model_hang = 1'b0;
      spur_done = 1'b0;

      vecs[0] = '{dc: 1'b1, data: 8'hA5, b2b: 1'b0, exp_data: 8'hA5, exp_dc: 1'b1};
      vecs[1] = '{dc: 1'b0, data: 8'h2A, b2b: 1'b1, exp_data: 8'h2A, exp_dc: 1'b0};
      vecs[2] = '{dc: 1'b1, data: 8'h00, b2b: 1'b0, exp_data: 8'h00, exp_dc: 1'b1};
      vecs[3] = '{dc: 1'b0, data: 8'hFF, b2b: 1'b0, exp_data: 8'hFF, exp_dc: 1'b0};
      vecs[4] = '{dc: 1'b1, data: 8'h3C, b2b: 1'b0, exp_data: 8'h3C, exp_dc: 1'b1};

      repeat (3) tick();
      chk_reset_vals("por");
      rst_n = 1'b1;

`ifdef SPI_SEQ_INIT_ROM_EN
      begin
         logic [7:0] exp_b  [5];
         logic       exp_dc [5];
         int         rdy_seen;
         exp_b[0] = 8'h01; exp_dc[0] = 1'b0;
         exp_b[1] = 8'h11; exp_dc[1] = 1'b0;
         exp_b[2] = 8'h3A; exp_dc[2] = 1'b0;
         exp_b[3] = 8'h55; exp_dc[3] = 1'b1;
         exp_b[4] = 8'h29; exp_dc[4] = 1'b0;
         rdy_seen = 0;
         n = 0;
         while (!lcd_rst_n && n < 100) begin
            n++;
            tick();
         end
         chk("rst_low_cycles", 32'(n), 4);
         n = 0;
         do begin
            tick();
            n++;
         end while (!spi_start && n < 100);
         chk("first_start_delay", 32'(n), 6);
         for (int b = 0; b < 5; b++) begin
            if (b > 0) begin
               n = 0;
               do begin
                  tick();
                  n++;
                  if (req_ready) rdy_seen++;
               end while (!spi_start && n < 300);
               if (b == 1) begin
                  checks++;
                  if (n - 1 < 14 || n - 1 > 16) begin
                     errors++;
                     $display("FAIL delay_gap: got %0d cycles, required 14..16", n - 1);
                  end
               end
            end
            chk("init_start", 32'(spi_start), 1);
            chk("init_byte", 32'(spi_data), 32'(exp_b[b]));
            chk("init_dc", 32'(lcd_dc), 32'(exp_dc[b]));
            n = 0;
            do begin
               tick();
               n++;
               if (req_ready) rdy_seen++;
            end while (!spi_done && n < 100);
         end
         n = 0;
         while (!init_done && n < 20) begin
            tick();
            n++;
         end
         chk("init_done_set", 32'(init_done), 1);
         chk("ready_at_init_done", 32'(req_ready), 1);
         chk("ready_during_init", 32'(rdy_seen), 0);
      end
`else
      tick();
      chk("init_done_1cyc", 32'(init_done), 1);
      chk("ready_1cyc", 32'(req_ready), 1);
`endif
      chk("idle_busy", 32'(busy), 0);
      chk("idle_lcd_rst_n", 32'(lcd_rst_n), 1);

      for (int i = 0; i < NV; i++) run_vec(i);

      // A done pulse while idle must be ignored
      spur_done = 1'b1;
      tick();
      spur_done = 1'b0;
      tick();
      chk("spur_ready", 32'(req_ready), 1);
      chk("spur_busy", 32'(busy), 0);
      chk("spur_fault", 32'(fault), 0);

      // Timeout: master never answers
      model_hang = 1'b1;
      req_valid = 1'b1;
      req_dc = 1'b0;
      req_data = 8'h5A;
      tick();
      chk("to_start", 32'(spi_start), 1);
      n = 0;
      while (!fault && n < 200) begin
         tick();
         n++;
      end
      chk("timeout_cycles", 32'(n), 50);
      chk("fault_ready", 32'(req_ready), 0);
      chk("fault_busy", 32'(busy), 0);
      starts = 0;
      repeat (5) begin
         tick();
         if (spi_start || req_ready) starts++;
      end
      chk("fault_quiet", 32'(starts), 0);
      req_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      chk_reset_vals("fault_rst");
      model_hang = 1'b0;
      tick();
      rst_n = 1'b1;
      wait_ready();

      // Reset in the middle of a transfer
      req_valid = 1'b1;
      req_dc = 1'b1;
      req_data = 8'hC3;
      tick();
      chk("mid_start", 32'(spi_start), 1);
      req_valid = 1'b0;
      repeat (5) tick();
      chk("mid_busy", 32'(busy), 1);
      rst_n = 1'b0;
      tick();
      chk_reset_vals("mid_rst");
      rst_n = 1'b1;
      wait_ready();
      run_vec(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
